// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode stage.
// Optional FETCH_HALT_EN turns the 8'hFF word into a halt instruction.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int OPC_W   = 3;
  localparam int IMM_W   = 5;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_WORD = 8'hFF;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    OUT    = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_decode_pc_reg.sv
// Program counter register: synchronous reset, load (branch) wins over increment.
module pc_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] target_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o
);

  logic [W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch and field split: REQ -> WAIT -> OUT loop with branch squash.
// Define FETCH_HALT_EN to make word 8'hFF stop fetching until reset.
module fetch_decode #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 3,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic [1:0]        dbg_state
);

  import fetch_pkg::*;

  // Handshake: a word transfers on every rising edge where out_valid && out_ready;
  // opcode/imm/pc_out are held stable while out_valid is high and out_ready is low.

  state_t state_q, state_d;
  logic squash_q, squash_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] pc;
  logic pc_load, pc_inc;

  pc_reg #(.W(ADDR_W)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load),
    .target_i (branch_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    pc_out_d = pc_out_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    case (state_q)
      REQ: begin
        state_d = WAIT;
        // The request already left this cycle, so its reply must be dropped.
        if (branch_en) begin
          pc_load  = 1'b1;
          squash_d = 1'b1;
        end
      end
      WAIT: begin
        if (branch_en) begin
          pc_load = 1'b1;
          if (mem_valid) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (mem_valid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            opcode_d = mem_rdata[IMM_W +: OPC_W];
            imm_d    = mem_rdata[IMM_W-1:0];
            pc_out_d = pc;
            pc_inc   = 1'b1;
            state_d  = OUT;
          end
        end
      end
      OUT: begin
`ifdef FETCH_HALT_EN
        if (out_ready && ({opcode_q, imm_q} == HALT_WORD)) begin
          state_d = HALTED;
        end else
`endif
        if (branch_en) begin
          pc_load = 1'b1;
          state_d = REQ;
        end else if (out_ready) begin
          state_d = REQ;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: begin
        state_d = HALTED;
      end
`endif
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      squash_q <= 1'b0;
      opcode_q <= '0;
      imm_q    <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign mem_req   = (state_q == REQ) && !rst;
  assign mem_addr  = pc;
  assign out_valid = (state_q == OUT) && !rst;
  assign opcode    = opcode_q;
  assign imm       = imm_q;
  assign pc_out    = pc_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: vector table plus branch/wrap/halt/reset sequences.
module tb_fetch_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_valid;
  logic       branch_en;
  logic [7:0] branch_target;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] opcode;
  logic [4:0] imm;
  logic [7:0] pc_out;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opcode        (opcode),
    .imm           (imm),
    .pc_out        (pc_out),
    .dbg_state     (dbg_state)
  );

  typedef struct {
    logic [7:0] word;
    int         lat;
    int         hold;
    logic [7:0] exp_addr;
    logic [2:0] exp_opc;
    logic [4:0] exp_imm;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic [7:0] exp_addr);
    int n;
    n = 0;
    #1;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'b0, mem_req}, 32'd1);
    chk("mem_addr", {24'b0, mem_addr}, {24'b0, exp_addr});
  endtask

  // Called in REQ: moves to WAIT, returns the word after lat cycles, ends in OUT.
  task automatic respond(input logic [7:0] word, input int lat);
    @(negedge clk);
    chk("wait_no_req", {31'b0, mem_req}, 32'd0);
    repeat (lat - 1) @(negedge clk);
    mem_rdata = word;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = 8'($urandom_range(0, 255));
  endtask

  task automatic check_out(input logic [7:0] epc, input logic [2:0] eopc, input logic [4:0] eimm);
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    chk("opcode", {29'b0, opcode}, {29'b0, eopc});
    chk("imm", {27'b0, imm}, {27'b0, eimm});
    chk("pc_out", {24'b0, pc_out}, {24'b0, epc});
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{word: 8'hA5, lat: 1, hold: 0, exp_addr: 8'h00, exp_opc: 3'b101, exp_imm: 5'b00101};
    vecs[1] = '{word: 8'h3C, lat: 3, hold: 5, exp_addr: 8'h01, exp_opc: 3'b001, exp_imm: 5'b11100};
    vecs[2] = '{word: 8'h00, lat: 2, hold: 1, exp_addr: 8'h02, exp_opc: 3'b000, exp_imm: 5'b00000};
    vecs[3] = '{word: 8'h7E, lat: 1, hold: 0, exp_addr: 8'h03, exp_opc: 3'b011, exp_imm: 5'b11110};

    rst = 1'b1;
    mem_rdata = 8'h00;
    mem_valid = 1'b0;
    branch_en = 1'b0;
    branch_target = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_opcode", {29'b0, opcode}, 32'd0);
    chk("rst_imm", {27'b0, imm}, 32'd0);
    chk("rst_pc_out", {24'b0, pc_out}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wait_req(vecs[i].exp_addr);
      respond(vecs[i].word, vecs[i].lat);
      check_out(vecs[i].exp_addr, vecs[i].exp_opc, vecs[i].exp_imm);
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(negedge clk);
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_fields", {24'b0, opcode, imm}, {24'b0, vecs[i].word});
        chk("hold_no_req", {31'b0, mem_req}, 32'd0);
      end
      handshake();
    end

    // Branch while waiting; the late reply 8'h12 must be discarded.
    wait_req(8'h04);
    @(negedge clk);
    branch_en = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    branch_en = 1'b0;
    mem_rdata = 8'h12;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("squash_no_valid", {31'b0, out_valid}, 32'd0);
    wait_req(8'h40);

    // Branch together with out_ready in OUT.
    respond(8'h81, 1);
    check_out(8'h40, 3'b100, 5'b00001);
    branch_en = 1'b1;
    branch_target = 8'hFE;
    out_ready = 1'b1;
    @(negedge clk);
    branch_en = 1'b0;
    out_ready = 1'b0;
    chk("br_rdy_drop", {31'b0, out_valid}, 32'd0);
    wait_req(8'hFE);

    // Branch in OUT without ready drops the held word.
    respond(8'h55, 2);
    check_out(8'hFE, 3'b010, 5'b10101);
    branch_en = 1'b1;
    branch_target = 8'hF0;
    @(negedge clk);
    branch_en = 1'b0;
    chk("br_out_drop", {31'b0, out_valid}, 32'd0);
    wait_req(8'hF0);

    // Branch in REQ: the reply to the issued request is squashed.
    branch_en = 1'b1;
    branch_target = 8'hFF;
    @(negedge clk);
    branch_en = 1'b0;
    chk("br_req_wait", {31'b0, mem_req}, 32'd0);
    mem_rdata = 8'h99;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("br_req_squash", {31'b0, out_valid}, 32'd0);
    wait_req(8'hFF);

    // Fetch of 8'hFF at address 8'hFF: PC wraps.
    respond(8'hFF, 1);
    check_out(8'hFF, 3'b111, 5'b11111);
    handshake();
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 8; k++) begin
      branch_en = (k == 2);
      branch_target = 8'h10;
      @(negedge clk);
      chk("halt_quiet", {30'b0, mem_req, out_valid}, 32'd0);
    end
    branch_en = 1'b0;
`else
    wait_req(8'h00);
    @(negedge clk);
    chk("wrap_wait", {31'b0, mem_req}, 32'd0);
`endif

    // Reset mid-fetch; a stale reply right after reset is ignored.
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_req", {31'b0, mem_req}, 32'd0);
    chk("rst2_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    mem_rdata = 8'hEE;
    mem_valid = 1'b1;
    #1;
    chk("rst2_req_after", {31'b0, mem_req}, 32'd1);
    chk("rst2_addr", {24'b0, mem_addr}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("stale_ignored", {30'b0, mem_req, out_valid}, 32'd0);
    mem_rdata = 8'h6B;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    check_out(8'h00, 3'b011, 5'b01011);
    handshake();
    wait_req(8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
